i2c_target_rx: RTL and testbench
================================

# i2c_target_rx

Write-only I2C target (slave) receiver for the shared I2C lines driven by the FPGA's brute-force bus master. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches the 7-bit address, ACKs each byte by pulling SDA low, and presents every received data byte on a one-cycle strobe. It sits at the far end of a bus line (loopback/self-test target, or a second FPGA on the same bus) and hands bytes to downstream register logic.

## Interface
- ADDRESS, 7'h50, 7-bit target address that is matched and ACKed.
- MAXBYTES, 8, data bytes ACKed per transfer; later bytes are NACKed and not strobed.

- CLK  input  1  system clock; every SCL high and low phase is at least 8 CLK cycles.
- RESET  input  1  asynchronous, active-high reset.
- SCL_IN  input  1  raw SCL level; asynchronous to CLK.
- SDA_IN  input  1  raw SDA level; asynchronous to CLK.
- SDA_OE  output  1  1 = pull SDA low (open-drain); 0 = release.
- RXDATA  output  8  last received data byte, MSB first on the wire.
- RXVALID  output  1  one-cycle strobe; RXDATA is new this cycle.
- RXFIRST  output  1  qualifies RXVALID: byte is the first data byte after an address match.
- BYTECOUNT  output  8  data bytes strobed in the current transfer; cleared on START.
- BUSY  output  1  high from an address match to STOP or repeated START.
- STOPSEEN  output  1  one-cycle strobe on every detected STOP.

## Operation
- SCL_IN and SDA_IN each pass through a 2-flop synchronizer plus one history flop.
  - sclr = SCL rising, sclf = SCL falling.
  - START = SDA falls while SCL is high; STOP = SDA rises while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- Global transitions, taking priority over everything else:
  - START in any state -> ADDR; bit counter = 0, shift register = 0, BYTECOUNT = 0, SDA_OE = 0.
  - STOP in any state -> IDLE; SDA_OE = 0, BUSY = 0, STOPSEEN pulses.
- IDLE: waits for START.
- ADDR: shifts SDA into the shift register on each sclr. After 8 bits, at the following sclf:
  - {addr[6:0], rw} matches with rw = 0 -> ADDR_ACK, SDA_OE = 1, BUSY = 1.
  - Address mismatch, or rw = 1 (reads not supported) -> IGNORE, SDA_OE stays 0.
- ADDR_ACK: holds SDA_OE = 1 through the 9th SCL pulse. At the sclf ending it: SDA_OE = 0 -> DATA.
- DATA: shifts 8 bits on sclr. On the 8th sclr:
  - If BYTECOUNT < MAXBYTES: RXDATA = byte, RXVALID = 1, RXFIRST = (BYTECOUNT == 0), BYTECOUNT increments. At the next sclf: SDA_OE = 1 -> DATA_ACK.
  - Otherwise: no strobe, SDA_OE stays 0 (NACK) -> IGNORE at the next sclf.
- DATA_ACK: same release rule as ADDR_ACK -> DATA.
- IGNORE: SDA_OE = 0; leaves only on START or STOP.
- BYTECOUNT never exceeds MAXBYTES; RXDATA holds its value until the next strobe.
- The SDA value sampled during ACK slots is never shifted in.

## Timing
- Reset values: SDA_OE = 0, RXDATA = 8'h00, RXVALID = 0, RXFIRST = 0, BYTECOUNT = 0, BUSY = 0, STOPSEEN = 0; state IDLE.
- Synchronizer latency:
  - An input change is visible to edge detection 2 CLK later.
  - An event is acted on at the 3rd CLK edge after the pin change.
- RXVALID is asserted on the CLK cycle after the 8th data sclr is detected, for exactly 1 cycle.
- SDA_OE asserts 1 CLK after the sclf detected after the 8th bit, well inside SCL low.
- SDA_OE releases 1 CLK after the sclf ending the 9th clock.
- Simultaneous sclr and SDA change in the same sample: the SDA change is ignored as START/STOP; SCL must be stable high for START/STOP to count.
- RESET mid-byte: everything drops to reset values immediately and asynchronously, SDA_OE included. The next START restarts cleanly.

## Test plan
- START, 0xA0 (0x50 write), 0x12, 0x34, 0x56, STOP:
  - ACKs on all 4 ninth clocks.
  - 3 RXVALID pulses with RXDATA 0x12/0x34/0x56; RXFIRST only on 0x12.
  - BYTECOUNT = 3, STOPSEEN once, BUSY low after STOP.
- START, 0xA2 (address 0x51), 0xFF, STOP:
  - SDA_OE never asserts, no RXVALID, BUSY stays 0.
- START, 0xA1 (read to 0x50): NACK, IGNORE until STOP, no strobes.
- MAXBYTES = 2, send 0xA0, 0x01, 0x02, 0x03:
  - ACK for the first three bytes, NACK for 0x03.
  - Two strobes only; BYTECOUNT = 2.
- Repeated START after 0xA0, 0x11, then 0xA0, 0x22, STOP:
  - BYTECOUNT resets, then reaches 1.
  - Both 0x11 and 0x22 strobe with RXFIRST = 1.
- Assert RESET during the 5th bit of a data byte:
  - SDA_OE = 0 and all outputs at reset values that cycle.
  - A following full frame 0xA0, 0x7E is received correctly.

Source files
------------

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - write-only I2C target receiver with address match, ACK and byte strobe
module i2c_target_rx #(
  parameter logic [6:0] ADDRESS  = 7'h50,
  parameter int         MAXBYTES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] RXDATA,
  output logic       RXVALID,
  output logic       RXFIRST,
  output logic [7:0] BYTECOUNT,
  output logic       BUSY,
  output logic       STOPSEEN
);

  localparam logic [7:0] MAXB = 8'(MAXBYTES);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  state_t     state_q, state_d;
  logic       scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic [7:0] rxdata_d, bytecount_d;
  logic       rxvalid_d, rxfirst_d, busy_d, oe_d, stopseen_d;
  logic       sclr, sclf, start_det, stop_det;

  // Synchronizers reset to the idle bus level so reset release creates no edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {SCL_IN, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {SDA_IN, sda_s1, sda_s2};
    end
  end

  assign sclr = scl_s2 & ~scl_h;
  assign sclf = ~scl_s2 & scl_h;
  // SCL must be high in both samples, so an SDA change coincident with sclr is not START/STOP.
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ack_q     <= 1'b0;
      RXDATA    <= '0;
      RXVALID   <= 1'b0;
      RXFIRST   <= 1'b0;
      BYTECOUNT <= '0;
      BUSY      <= 1'b0;
      SDA_OE    <= 1'b0;
      STOPSEEN  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      RXDATA    <= rxdata_d;
      RXVALID   <= rxvalid_d;
      RXFIRST   <= rxfirst_d;
      BYTECOUNT <= bytecount_d;
      BUSY      <= busy_d;
      SDA_OE    <= oe_d;
      STOPSEEN  <= stopseen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    rxdata_d    = RXDATA;
    rxvalid_d   = 1'b0;
    rxfirst_d   = 1'b0;
    bytecount_d = BYTECOUNT;
    busy_d      = BUSY;
    oe_d        = SDA_OE;
    stopseen_d  = 1'b0;
    if (stop_det) begin
      state_d    = IDLE;
      oe_d       = 1'b0;
      busy_d     = 1'b0;
      stopseen_d = 1'b1;
    end else if (start_det) begin
      state_d     = ADDR;
      cnt_d       = '0;
      shift_d     = '0;
      bytecount_d = '0;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (sclr && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s2};
            cnt_d   = cnt_q + 4'd1;
          end else if (sclf && cnt_q == 4'd8) begin
            if (shift_q == {ADDRESS, 1'b0}) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // Entered on the sclf after bit 8, so the next sclf ends the ACK clock.
          if (sclf) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (sclr && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s2};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              ack_d = (BYTECOUNT < MAXB);
              if (BYTECOUNT < MAXB) begin
                rxdata_d    = {shift_q[6:0], sda_s2};
                rxvalid_d   = 1'b1;
                rxfirst_d   = (BYTECOUNT == 8'd0);
                bytecount_d = BYTECOUNT + 8'd1;
              end
            end
          end else if (sclf && cnt_q == 4'd8) begin
            if (ack_q) begin
              state_d = DATA_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE: oe_d = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - randomized directed bench for i2c_target_rx against a frame-level model
module tb_i2c_target_rx;

  localparam int H = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda = 1'b1;

  logic       oe1, rxv1, rxf1, busy1, stop1;
  logic [7:0] rxd1, bc1;
  logic       oe2, rxv2, rxf2, busy2, stop2;
  logic [7:0] rxd2, bc2;

  int tests = 0;
  int fails = 0;

  logic [7:0] frame[$];
  logic [8:0] got1[$], got2[$];
  logic       ack1[$], ack2[$];
  logic       oe_any1, oe_any2;
  int         stops1, stops2;

  always #5 clk = ~clk;

  i2c_target_rx u_dut1 (
    .CLK(clk), .RESET(rst), .SCL_IN(scl), .SDA_IN(sda), .SDA_OE(oe1),
    .RXDATA(rxd1), .RXVALID(rxv1), .RXFIRST(rxf1), .BYTECOUNT(bc1),
    .BUSY(busy1), .STOPSEEN(stop1)
  );

  i2c_target_rx #(.ADDRESS(7'h50), .MAXBYTES(2)) u_dut2 (
    .CLK(clk), .RESET(rst), .SCL_IN(scl), .SDA_IN(sda), .SDA_OE(oe2),
    .RXDATA(rxd2), .RXVALID(rxv2), .RXFIRST(rxf2), .BYTECOUNT(bc2),
    .BUSY(busy2), .STOPSEEN(stop2)
  );

  always @(negedge clk) begin
    if (rxv1) got1.push_back({rxf1, rxd1});
    if (rxv2) got2.push_back({rxf2, rxd2});
    if (oe1) oe_any1 = 1'b1;
    if (oe2) oe_any2 = 1'b1;
    if (stop1) stops1++;
    if (stop2) stops2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b);
    sda = b;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    scl = 1'b0;
    wait_clk(3);
  endtask

  task automatic ack_slot();
    sda = 1'b1;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H / 2);
    @(negedge clk);
    ack1.push_back(oe1);
    ack2.push_back(oe2);
    wait_clk(H / 2);
    scl = 1'b0;
    wait_clk(3);
  endtask

  task automatic start_cond();
    sda = 1'b1;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda = 1'b0;
    wait_clk(H);
    scl = 1'b0;
    wait_clk(3);
  endtask

  task automatic stop_cond();
    sda = 1'b0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda = 1'b1;
    wait_clk(H);
  endtask

  // Frame-level reference: one ACK per byte while matched and under the byte limit,
  // strobes are the first maxb data bytes, the first one flagged.
  task automatic check_dut(input string nm, input int maxb, input logic ack[$],
                           input logic [8:0] got[$], input logic [7:0] bc,
                           input logic busy, input logic oe_any);
    bit match;
    int ndata, nexp;
    logic exp_ack;
    match = (frame[0] == 8'hA0);
    ndata = frame.size() - 1;
    nexp  = match ? ((ndata < maxb) ? ndata : maxb) : 0;
    for (int i = 0; i < frame.size(); i++) begin
      exp_ack = (i == 0) ? match : (match && (i - 1) < maxb);
      chk($sformatf("%s ack[%0d]", nm, i), 32'(ack[i]), 32'(exp_ack));
    end
    chk($sformatf("%s strobes", nm), got.size(), nexp);
    for (int j = 0; j < nexp && j < got.size(); j++)
      chk($sformatf("%s rx[%0d]", nm, j), 32'(got[j]), {23'd0, (j == 0), frame[j + 1]});
    chk($sformatf("%s bytecount", nm), 32'(bc), nexp);
    chk($sformatf("%s busy", nm), 32'(busy), 32'(match));
    if (!match) chk($sformatf("%s oe_never", nm), 32'(oe_any), 32'd0);
  endtask

  task automatic xfer(input bit do_stop);
    int s1, s2;
    got1.delete(); got2.delete(); ack1.delete(); ack2.delete();
    oe_any1 = 1'b0;
    oe_any2 = 1'b0;
    start_cond();
    foreach (frame[k]) begin
      for (int b = 7; b >= 0; b--) put_bit(frame[k][b]);
      ack_slot();
    end
    check_dut("d8", 8, ack1, got1, bc1, busy1, oe_any1);
    check_dut("d2", 2, ack2, got2, bc2, busy2, oe_any2);
    if (do_stop) begin
      s1 = stops1;
      s2 = stops2;
      stop_cond();
      chk("stopseen1", stops1 - s1, 1);
      chk("stopseen2", stops2 - s2, 1);
      chk("busy1 after stop", 32'(busy1), 0);
      chk("oe1 after stop", 32'(oe1), 0);
    end
  endtask

  initial begin
    stops1 = 0;
    stops2 = 0;
    wait_clk(4);
    @(negedge clk);
    chk("rst oe", 32'(oe1), 0);
    chk("rst rxdata", 32'(rxd1), 0);
    chk("rst rxvalid", 32'(rxv1), 0);
    chk("rst rxfirst", 32'(rxf1), 0);
    chk("rst bytecount", 32'(bc1), 0);
    chk("rst busy", 32'(busy1), 0);
    chk("rst stopseen", 32'(stop1), 0);
    rst = 1'b0;
    wait_clk(5);

    frame = '{8'hA0, 8'h12, 8'h34, 8'h56};
    xfer(1);
    frame = '{8'hA2, 8'hFF};
    xfer(1);
    frame = '{8'hA1, 8'($urandom)};
    xfer(1);
    frame = '{8'hA0, 8'h01, 8'h02, 8'h03};
    xfer(1);
    frame = '{8'hA0, 8'h11};
    xfer(0);
    frame = '{8'hA0, 8'h22};
    xfer(1);

    for (int r = 0; r < 6; r++) begin
      int n;
      frame.delete();
      frame.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hA0);
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
      xfer(1);
    end

    // Asynchronous reset while SCL is high during the 5th bit of a data byte.
    start_cond();
    for (int b = 7; b >= 0; b--) put_bit(1'(8'hA0 >> b));
    ack_slot();
    for (int b = 0; b < 4; b++) put_bit(1'b1);
    sda = 1'b0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(3);
    #2 rst = 1'b1;
    #1;
    chk("mid rst oe", 32'(oe1), 0);
    chk("mid rst rxdata", 32'(rxd1), 0);
    chk("mid rst bytecount", 32'(bc1), 0);
    chk("mid rst busy", 32'(busy1), 0);
    chk("mid rst rxvalid", 32'(rxv1), 0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(H);
    scl = 1'b0;
    wait_clk(H);
    frame = '{8'hA0, 8'h7E};
    xfer(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
